// File: rtl/bram_window_reader_pkg.sv
// audio_pkg: shared sizes, reader FSM states and window slice helper for the BRAM window reader.
package audio_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int TAPS   = 5;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE_ONLY} stateT;

    // Lowest bit of window slice k, where slice k holds sample s[i-k].
    function automatic int sliceLo(input int k);
        return k * DATA_W;
    endfunction

endpackage

// File: rtl/bram_window_reader_if.sv
// bram_window_reader_if: window stream from the reader (master) to the FIR filter (slave).
//   win_valid/win_ready  handshake
//   win_data             TAPS slices, slice 0 = newest sample
//   win_index            sample index within the run
//   win_last             window holds the final sample of the run
interface bram_window_reader_if
    import audio_pkg::*;
;
    logic                   win_valid;
    logic                   win_ready;
    logic [TAPS*DATA_W-1:0] win_data;
    logic [ADDR_W-1:0]      win_index;
    logic                   win_last;

    modport master (output win_valid, win_data, win_index, win_last, input win_ready);
    modport slave  (input win_valid, win_data, win_index, win_last, output win_ready);

endinterface

// File: rtl/bram_window_reader_fifo.sv
// sample_skid_fifo: 2-entry sample buffer absorbing BRAM returns while the window is stalled.
//   clk, rst_n          clock, asynchronous active-low reset
//   push, pushData      write one sample
//   pop, popData        head sample (valid while count != 0), pop removes it
//   count               occupancy 0..2
module sample_skid_fifo
    import audio_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] pushData,
    input  logic         pop,
    output logic [W-1:0] popData,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wrPtr;
    logic         rdPtr;

    assign popData = mem[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= ~wrPtr;
            end
            if (pop) rdPtr <= ~rdPtr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // The reader's issue throttle guarantees these never happen.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && count == 2'd2));
    assert property (@(posedge clk) disable iff (!rst_n) !(pop && count == 2'd0));

endmodule

// File: rtl/bram_window_reader.sv
// bram_window_reader: streams a run of BRAM samples into a zero-padded TAPS-deep sliding window.
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, base_addr, length    launch a run (accepted while busy=0)
//   busy, done                  run in progress / one-cycle completion pulse
//   bram_en, bram_addr          BRAM read port, data returns on bram_rdata one cycle later
//   win (master)                window stream to the FIR filter
module bram_window_reader
    import audio_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      length,
    output logic                 busy,
    output logic                 done,
    output logic                 bram_en,
    output logic [ADDR_W-1:0]    bram_addr,
    input  logic [DATA_W-1:0]    bram_rdata,
    bram_window_reader_if.master win
);
    localparam logic [ADDR_W:0] ONE = 1;

    stateT                  state, nextState;
    logic [ADDR_W-1:0]      baseAddr, winIndex;
    logic [ADDR_W:0]        len, issued, loadCnt;
    logic                   inflight, winValid, winLast, doneQ;
    logic                   startAcc, load, push, pop, fifoEmpty;
    logic [TAPS*DATA_W-1:0] history;
    logic [DATA_W-1:0]      fifoData, sample;
    logic [1:0]             fifoCount;

    sample_skid_fifo #(.W(DATA_W)) fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pushData (bram_rdata),
        .pop      (pop),
        .popData  (fifoData),
        .count    (fifoCount)
    );

    assign busy          = state == STREAM || state == DRAIN;
    assign done          = doneQ;
    assign bram_addr     = baseAddr + issued[ADDR_W-1:0];
    assign win.win_valid = winValid;
    assign win.win_data  = history;
    assign win.win_index = winIndex;
    assign win.win_last  = winLast;

    always_comb begin
        startAcc  = start && !busy;
        bram_en   = state == STREAM && issued < len && (3'(fifoCount) + 3'(inflight)) < 3'd2;
        fifoEmpty = fifoCount == 2'd0;
        // Returning data bypasses the FIFO when it is empty and the window can take it.
        load      = (!fifoEmpty || inflight) && (!winValid || win.win_ready);
        push      = inflight && !(load && fifoEmpty);
        pop       = load && !fifoEmpty;
        sample    = fifoEmpty ? bram_rdata : fifoData;
        nextState = state;
        if (state == IDLE || state == DONE_ONLY)
            nextState = startAcc ? (length == '0 ? DONE_ONLY : STREAM) : IDLE;
        else if (state == STREAM)
            nextState = (bram_en && issued + ONE == len) ? DRAIN : STREAM;
        else
            nextState = (winValid && win.win_ready && winLast) ? IDLE : DRAIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doneQ    <= 1'b0;
            inflight <= 1'b0;
            baseAddr <= '0;
            len      <= '0;
            issued   <= '0;
            loadCnt  <= '0;
            history  <= '0;
            winValid <= 1'b0;
            winIndex <= '0;
            winLast  <= 1'b0;
        end else begin
            doneQ    <= (state == DRAIN && nextState == IDLE) || (startAcc && length == '0);
            inflight <= bram_en;
            if (startAcc) begin
                baseAddr <= base_addr;
                len      <= length;
                issued   <= '0;
                loadCnt  <= '0;
                history  <= '0;
            end else begin
                if (bram_en) issued <= issued + ONE;
                if (load) begin
                    history  <= {history[(TAPS-1)*DATA_W-1:0], sample};
                    winValid <= 1'b1;
                    winIndex <= loadCnt[ADDR_W-1:0];
                    winLast  <= loadCnt + ONE == len;
                    loadCnt  <= loadCnt + ONE;
                end else if (win.win_ready) begin
                    winValid <= 1'b0;
                end
            end
        end
    end

endmodule
